fp_mac_seq: RTL and testbench
=============================

Name: fp_mac_seq

Overview:
Sequencer that turns the free-running fp_mac (single-precision multiply-accumulate) into a transaction-level dot-product engine.
- Accepts a stream of IEEE-754 operand pairs over a valid/ready handshake, with a last flag ending each vector.
- Clears the MAC accumulator before the first beat and feeds it one pair per accepted beat.
- Drains the MAC pipeline after the last beat, then returns the 32-bit dot product and beat count on a valid/ready result port.
- Sits between the operand source (DMA/testbench) and one fp_mac instance.

Parameters:
MAC_LAT, 2, cycles from operands on mac_a/mac_b to their product being included in mac_out (fp_mac pipeline depth)
CNT_W, 8, width of the beat counter / res_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  sequencer accepts pair this cycle
in_a  in  32  operand A, IEEE-754 single
in_b  in  32  operand B, IEEE-754 single
in_last  in  1  marks final pair of the vector
mac_a  out  32  to fp_mac a
mac_b  out  32  to fp_mac b
mac_clr  out  1  to fp_mac reset (clears accumulator)
mac_out  in  32  from fp_mac out
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  32  dot-product result, IEEE-754 single
res_count  out  CNT_W  number of beats accumulated, saturating

Behaviour:
- Reset (async, reset=1) values:
  - state=IDLE; in_ready=0, res_valid=0.
  - mac_a=mac_b=0, mac_clr=1.
  - res_data=0, res_count=0; beat and drain counters 0.
- All outputs are registered. A handshake occurs when valid&ready are high at a rising edge.
- States:
  - IDLE: in_ready=0, mac_clr=0. If in_valid=1, go to CLEAR. The pending beat is not consumed.
  - CLEAR:
    - Exactly 1 cycle: mac_clr=1, mac_a=mac_b=0.
    - Beat counter cleared, then go to RUN.
  - RUN:
    - in_ready=1. An accepted beat at cycle T drives mac_a/mac_b with in_a/in_b during T+1 only.
    - Non-handshake cycles drive mac_a=mac_b=32'h0 (adds +0; the accumulator is unaffected).
    - Each accepted beat increments the beat counter, which saturates at all-ones.
    - A beat with in_last=1 goes to DRAIN and loads the drain counter with MAC_LAT.
  - DRAIN:
    - in_ready=0, operands zero; the drain counter decrements each cycle.
    - In the cycle the counter reads 0, register mac_out into res_data and the beat count into res_count, then go to DONE.
  - DONE:
    - res_valid=1, in_ready=0. res_data and res_count are held stable while res_ready=0.
    - When res_ready=1: handshake, res_valid drops next cycle, go to IDLE.
- Latency: last beat accepted at T → res_valid=1 from cycle T+2+MAC_LAT.
- Minimum per-vector overhead: 1 IDLE + 1 CLEAR + MAC_LAT + 2 cycles.
- Boundary conditions:
  - Single-beat vector (first beat has last=1) is legal.
  - Gaps in in_valid during RUN are allowed.
  - in_valid/in_a/in_b are ignored in every state except RUN.
  - Beat counter saturates at 2^CNT_W-1; the accumulation itself continues.
  - Reset asserted in any state aborts the transaction. Outputs take reset values immediately and the partial result is discarded.
  - The sequencer performs no FP arithmetic. NaN/Inf/denormal propagation is fp_mac's behaviour.

Decomposition:
- Shared package fp_mac_pkg:
  - state enum {IDLE, CLEAR, RUN, DRAIN, DONE};
  - FP_W=32 and the FP_ZERO constant (32'h0);
  - default MAC_LAT.
- No sub-module: a single FSM with two counters.
- fp_mac is instantiated by the parent beside fp_mac_seq, not inside it.

Test Plan:
1. Single beat: a=40400000 (3.0), b=40000000 (2.0), last=1 → res_data=40C00000 (6.0), res_count=1, res_valid at T+2+MAC_LAT.
2. Two beats: (40400000, 40000000), then (3FC00000 1.5, C0000000 -2.0, last) → res_data=40400000 (3.0), res_count=2.
3. Gapped input: the same two beats with in_valid low for 3 cycles between them → identical result; mac_a=0 during the gap cycles.
4. Back-to-back vectors with res_ready held low 5 cycles → res_valid and res_data stable, in_ready=0. After release: IDLE, CLEAR pulse (mac_clr=1 for 1 cycle), and the second result (41000000 for 4.0*2.0) is not contaminated by the first.
5. Reset mid-RUN after 2 beats → all outputs at reset values next sample, no res_valid. A following 1-beat vector returns the correct product.
6. Saturation with CNT_W=2: 5 beats of (3F800000, 3F800000) → res_data=40A00000 (5.0), res_count=3.

Source files
------------

// File: rtl/fp_mac_pkg.sv
// Shared definitions for the fp_mac sequencer.
//   state_e      : sequencer FSM states
//   FP_W/FP_ZERO : IEEE-754 single word width and +0.0 encoding
//   MAC_LAT_DEF  : default fp_mac pipeline depth
package fp_mac_pkg;

  localparam int unsigned FP_W        = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam int unsigned MAC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/fp_mac_seq.sv
// Transaction sequencer for a free-running fp_mac: turns a stream of operand
// pairs (valid/ready, last-terminated) into one dot-product result.
//   clk, reset                      : clock, async active-high reset
//   in_valid/in_ready/in_a/in_b/in_last : operand pair stream
//   mac_a/mac_b/mac_clr/mac_out     : fp_mac operands, accumulator clear, result
//   res_valid/res_ready/res_data/res_count : result handshake, sum, beat count
// All outputs are registered.
module fp_mac_seq
  import fp_mac_pkg::*;
#(
  parameter int unsigned MAC_LAT = MAC_LAT_DEF,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic             in_last,
  output logic [FP_W-1:0]  mac_a,
  output logic [FP_W-1:0]  mac_b,
  output logic             mac_clr,
  input  logic [FP_W-1:0]  mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [FP_W-1:0]  res_data,
  output logic [CNT_W-1:0] res_count
);

  // Wide enough to hold MAC_LAT, and never zero-width.
  localparam int unsigned DW = $clog2(MAC_LAT + 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [FP_W-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic [FP_W-1:0]  res_data_q, res_data_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             in_ready_q, in_ready_d;
  logic             mac_clr_q, mac_clr_d;
  logic             res_valid_q, res_valid_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    drain_d     = drain_q;
    res_data_d  = res_data_q;
    res_count_d = res_count_q;
    // Idle operands are +0 so the accumulator is left untouched.
    mac_a_d     = FP_ZERO;
    mac_b_d     = FP_ZERO;

    unique case (state_q)
      StIdle: begin
        // The pending beat is only looked at; it is consumed later in StRun.
        if (in_valid) state_d = StClear;
      end
      StClear: begin
        beat_d  = '0;
        state_d = StRun;
      end
      StRun: begin
        if (in_valid && in_ready_q) begin
          mac_a_d = in_a;
          mac_b_d = in_b;
          if (beat_q != '1) beat_d = beat_q + 1'b1;
          if (in_last) begin
            drain_d = DW'(MAC_LAT);
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Last product reaches mac_out in the cycle the counter reads zero.
        if (drain_q == '0) begin
          res_data_d  = mac_out;
          res_count_d = beat_q;
          state_d     = StDone;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs are decoded from the state being entered.
    in_ready_d  = (state_d == StRun);
    mac_clr_d   = (state_d == StClear);
    res_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      drain_q     <= '0;
      mac_a_q     <= FP_ZERO;
      mac_b_q     <= FP_ZERO;
      res_data_q  <= FP_ZERO;
      res_count_q <= '0;
      in_ready_q  <= 1'b0;
      mac_clr_q   <= 1'b1;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      drain_q     <= drain_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      in_ready_q  <= in_ready_d;
      mac_clr_q   <= mac_clr_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_clr   = mac_clr_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_count = res_count_q;

endmodule

// File: tb/tb_fp_mac_seq.sv
// Directed bench for fp_mac_seq. Two instances share the stimulus: one with
// CNT_W=8, one with CNT_W=2 for the saturation case. Each drives its own
// behavioural 2-stage fp_mac model (product stage, accumulate stage).
module tb_fp_mac_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_last = 1'b0;
  logic        res_ready = 1'b0;

  logic        in_ready, mac_clr, res_valid;
  logic [31:0] mac_a, mac_b, mac_out, res_data;
  logic [7:0]  res_count;

  logic        in_ready2, mac_clr2, res_valid2;
  logic [31:0] mac_a2, mac_b2, mac_out2, res_data2;
  logic [1:0]  res_count2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_mac_seq #(.MAC_LAT(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mac_a(mac_a), .mac_b(mac_b),
    .mac_clr(mac_clr), .mac_out(mac_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_count(res_count)
  );

  fp_mac_seq #(.MAC_LAT(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mac_a(mac_a2), .mac_b(mac_b2),
    .mac_clr(mac_clr2), .mac_out(mac_out2), .res_valid(res_valid2),
    .res_ready(res_ready), .res_data(res_data2), .res_count(res_count2)
  );

  // Single <-> double conversion, sufficient for normal numbers and zero.
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:0] == 31'd0) d = {f[31], 63'd0};
    else d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  logic [31:0] p1, acc, p1b, accb;
  always @(posedge clk) begin
    if (mac_clr) begin
      p1  <= '0;
      acc <= '0;
    end else begin
      p1  <= r2f(f2r(mac_a) * f2r(mac_b));
      acc <= r2f(f2r(acc) + f2r(p1));
    end
    if (mac_clr2) begin
      p1b  <= '0;
      accb <= '0;
    end else begin
      p1b  <= r2f(f2r(mac_a2) * f2r(mac_b2));
      accb <= r2f(f2r(accb) + f2r(p1b));
    end
  end
  assign mac_out  = acc;
  assign mac_out2 = accb;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait for acceptance, check the operands reach the MAC.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%b required 1 within 20 cycles", in_ready);
    end
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    checks++;
    if (mac_a !== a || mac_b !== b) begin
      errors++;
      $display("FAIL beat_operands: mac_a=%h mac_b=%h required %h %h", mac_a, mac_b, a, b);
    end
  endtask

  // Called just after the last handshake edge; result is due 3 edges later.
  task automatic finish_vec(input logic [31:0] exp_data, input logic [7:0] exp_cnt,
                            input logic [1:0] exp_cnt2);
    int n = 0;
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL res_latency: cycles=%0d required 3", n);
    end
    checks++;
    if (res_data !== exp_data || res_count !== exp_cnt) begin
      errors++;
      $display("FAIL res_value: data=%h count=%0d required %h %0d",
               res_data, res_count, exp_data, exp_cnt);
    end
    checks++;
    if (res_valid2 !== 1'b1 || res_data2 !== exp_data || res_count2 !== exp_cnt2) begin
      errors++;
      $display("FAIL res_value_cnt2: valid=%b data=%h count=%0d required 1 %h %0d",
               res_valid2, res_data2, res_count2, exp_data, exp_cnt2);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL res_release: res_valid=%b required 0", res_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || mac_clr !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: in_ready=%b res_valid=%b mac_clr=%b required 0 0 1",
               in_ready, res_valid, mac_clr);
    end
    checks++;
    if (mac_a !== 32'h0 || mac_b !== 32'h0 || res_data !== 32'h0 || res_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: mac_a=%h mac_b=%h res_data=%h res_count=%0d required zeros",
               mac_a, mac_b, res_data, res_count);
    end
    reset = 1'b0;
    step();
    checks++;
    if (mac_clr !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ctrl: mac_clr=%b in_ready=%b res_valid=%b required 0 0 0",
               mac_clr, in_ready, res_valid);
    end
  endtask

  task automatic test_single_beat();
    send_beat(32'h4040_0000, 32'h4000_0000, 1'b1);
    finish_vec(32'h40C0_0000, 8'd1, 2'd1);
  endtask

  task automatic test_two_beats();
    send_beat(32'h4040_0000, 32'h4000_0000, 1'b0);
    send_beat(32'h3FC0_0000, 32'hC000_0000, 1'b1);
    finish_vec(32'h4040_0000, 8'd2, 2'd2);
  endtask

  task automatic test_gapped();
    send_beat(32'h4040_0000, 32'h4000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (mac_a !== 32'h0 || mac_b !== 32'h0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL gap_idle: mac_a=%h mac_b=%h in_ready=%b required 0 0 1",
                 mac_a, mac_b, in_ready);
      end
    end
    send_beat(32'h3FC0_0000, 32'hC000_0000, 1'b1);
    finish_vec(32'h4040_0000, 8'd2, 2'd2);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    send_beat(32'h4040_0000, 32'h4000_0000, 1'b1);
    while (!res_valid && n < 20) begin
      step();
      n++;
    end
    // Next vector is already waiting while the first result is held.
    in_valid = 1'b1;
    in_a = 32'h4080_0000;
    in_b = 32'h4000_0000;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'h40C0_0000 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_result: res_valid=%b res_data=%h in_ready=%b required 1 40c00000 0",
                 res_valid, res_data, in_ready);
      end
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || mac_clr !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: res_valid=%b mac_clr=%b required 0 0", res_valid, mac_clr);
    end
    step();
    checks++;
    if (mac_clr !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clear: mac_clr=%b in_ready=%b required 1 0", mac_clr, in_ready);
    end
    step();
    checks++;
    if (mac_clr !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_run: mac_clr=%b in_ready=%b required 0 1", mac_clr, in_ready);
    end
    send_beat(32'h4080_0000, 32'h4000_0000, 1'b1);
    finish_vec(32'h4100_0000, 8'd1, 2'd1);
  endtask

  task automatic test_reset_mid_run();
    send_beat(32'h4040_0000, 32'h4000_0000, 1'b0);
    send_beat(32'h3FC0_0000, 32'hC000_0000, 1'b0);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0 || mac_clr !== 1'b1 || mac_a !== 32'h0 ||
        res_data !== 32'h0 || res_count !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset: in_ready=%b res_valid=%b mac_clr=%b mac_a=%h res_data=%h cnt=%0d required 0 0 1 0 0 0",
               in_ready, res_valid, mac_clr, mac_a, res_data, res_count);
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_result: res_valid=%b required 0", res_valid);
    end
    send_beat(32'h3FC0_0000, 32'h4000_0000, 1'b1);
    finish_vec(32'h4040_0000, 8'd1, 2'd1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h3F80_0000, 32'h3F80_0000, (i == 4));
    end
    finish_vec(32'h40A0_0000, 8'd5, 2'd3);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_two_beats();
    test_gapped();
    test_back_to_back();
    test_reset_mid_run();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
